// File: rtl/arb_pkg.sv
// Shared types and the round-robin search helper for the weighted arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Widest requester count the search helper supports; callers zero-extend into it.
  localparam int ARB_MAX_N  = 16;
  localparam int ARB_MAX_PW = $clog2(ARB_MAX_N);
  localparam int ARB_DW     = 2 * ARB_MAX_N;

  // The doubled vector lets one subtract find the first request at or above ptr with wrap-around.
  function automatic logic [ARB_MAX_N-1:0] rr_pick(
    input logic [ARB_MAX_N-1:0]  req,
    input logic [ARB_MAX_PW-1:0] ptr,
    input int unsigned           n
  );
    logic [ARB_DW-1:0]    dbl;
    logic [ARB_DW-1:0]    sel;
    logic [ARB_MAX_N-1:0] lowMask;
    dbl     = (ARB_DW'(req) << n) | ARB_DW'(req);
    sel     = dbl & ~(dbl - (ARB_DW'(1) << ptr));
    lowMask = (ARB_MAX_N'(1) << n) - ARB_MAX_N'(1);
    return (sel[ARB_MAX_N-1:0] | ARB_MAX_N'(sel >> n)) & lowMask;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above ptr, wrapping modulo N.
module arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  import arb_pkg::*;

  localparam int IW = $clog2(N);

  always_comb begin
    onehot = N'(rr_pick(ARB_MAX_N'(req & mask), ARB_MAX_PW'(ptr), N));
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = IW'(i);
    end
    any = |onehot;
  end

endmodule

// File: rtl/arb_wrr_lock.sv
// N-way weighted round-robin arbiter with registered one-hot grant and per-channel packet credit.
// Build option ARB_PKT_LOCK_EN: grants span whole packets delimited by req_last; otherwise every beat ends a packet.
module arb_wrr_lock #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         req_last,
  input  logic [N*WW-1:0]      weight,
  input  logic                 ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_vld
);
  import arb_pkg::*;

  localparam int IW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gntId_q, gntId_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] credit_q, credit_d;
  logic          midPkt_q, midPkt_d;

  logic [N-1:0]  pickMask, pickOh, grantOh;
  logic [IW-1:0] pickPtr, pickIdx, grantIdx, ptrInc;
  logic [WW-1:0] grantWeight;
  logic          pickAny, busy, reqW, xfer, pktEnd, keep, withdraw, handOver, doGrant;

  assign busy = (state_q == ARB_BUSY);
  assign reqW = req[gntId_q];
  assign xfer = (|(gnt_q & req)) & ack;

`ifdef ARB_PKT_LOCK_EN
  assign pktEnd = xfer & req_last[gntId_q];
`else
  logic unusedReqLast;
  assign unusedReqLast = ^req_last;
  assign pktEnd        = xfer;
`endif

  // A requester that lets req fall before its packet's first beat gives the port up; a mid-packet drop is a protocol error.
  assign withdraw = busy & ~reqW & ~midPkt_q;
  assign keep     = pktEnd & reqW & (credit_q != '0);
  assign handOver = (pktEnd & ~keep) | withdraw;
  assign ptrInc   = (gntId_q == IW'(N - 1)) ? '0 : gntId_q + IW'(1);
  assign pickMask = busy ? ~gnt_q : '1;
  assign pickPtr  = busy ? ptrInc : ptr_q;

  arb_rr_pick #(.N(N)) uPick (
    .req    (req),
    .mask   (pickMask),
    .ptr    (pickPtr),
    .onehot (pickOh),
    .idx    (pickIdx),
    .any    (pickAny)
  );

  // On hand-over the ending requester is masked out, unless it is the only one still asking.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gntId_d  = gntId_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    midPkt_d = midPkt_q;
    doGrant  = 1'b0;
    grantIdx = pickIdx;
    grantOh  = pickOh;
    if (!busy) begin
      doGrant = pickAny;
    end else begin
      if (xfer) midPkt_d = ~pktEnd;
      if (keep) begin
        credit_d = credit_q - WW'(1);
      end else if (handOver) begin
        ptr_d = ptrInc;
        if (pickAny) begin
          doGrant = 1'b1;
        end else if (reqW) begin
          doGrant  = 1'b1;
          grantIdx = gntId_q;
          grantOh  = gnt_q;
        end else begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          gntId_d = '0;
        end
      end
    end
    grantWeight = weight[int'(grantIdx)*WW +: WW];
    if (doGrant) begin
      state_d  = ARB_BUSY;
      gnt_d    = grantOh;
      gntId_d  = grantIdx;
      midPkt_d = 1'b0;
      credit_d = (grantWeight == '0) ? '0 : grantWeight - WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gntId_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      midPkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gntId_q  <= gntId_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      midPkt_q <= midPkt_d;
    end
  end

  reqHeldMidPkt: assert property (@(posedge clk) disable iff (!rst) midPkt_q |-> req[gntId_q]);

  assign gnt     = gnt_q;
  assign gnt_id  = gntId_q;
  assign gnt_vld = |gnt_q;

endmodule
